// File: rtl/key_start_ctrl.sv
// Push-button start controller: synchronise + debounce key_n, issue a one-cycle start
// per debounced press, lock out starts until done, count dropped presses, flag stuck runs.
module key_start_ctrl #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int SYNC_STAGES     = 2,
  parameter int RUN_TIMEOUT     = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_n,
  input  logic       done,
  output logic       start,
  output logic       running,
  output logic       key_level,
  output logic [7:0] drop_cnt,
  output logic       timeout
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int RW = (RUN_TIMEOUT > 1) ? $clog2(RUN_TIMEOUT) : 1;

  typedef enum logic [1:0] {IDLE, START, RUN} state_t;

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CW-1:0]          db_cnt_q, db_cnt_d;
  logic                   key_level_q, key_level_d;
  logic                   key_level_dly_q, key_level_dly_d;
  state_t                 state_q, state_d;
  logic [RW-1:0]          run_cnt_q, run_cnt_d;
  logic [7:0]             drop_cnt_q, drop_cnt_d;
  logic                   timeout_q, timeout_d;
  logic                   start_q, start_d;
  logic                   running_q, running_d;
  logic                   sync_out, press, run_expired;

  assign sync_out = sync_q[SYNC_STAGES-1];
  assign press    = ~key_level_q & key_level_dly_q;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q          <= '1;
      db_cnt_q        <= '0;
      key_level_q     <= 1'b1;
      key_level_dly_q <= 1'b1;
      state_q         <= IDLE;
      run_cnt_q       <= '0;
      drop_cnt_q      <= '0;
      timeout_q       <= 1'b0;
      start_q         <= 1'b0;
      running_q       <= 1'b0;
    end else begin
      sync_q          <= sync_d;
      db_cnt_q        <= db_cnt_d;
      key_level_q     <= key_level_d;
      key_level_dly_q <= key_level_dly_d;
      state_q         <= state_d;
      run_cnt_q       <= run_cnt_d;
      drop_cnt_q      <= drop_cnt_d;
      timeout_q       <= timeout_d;
      start_q         <= start_d;
      running_q       <= running_d;
    end
  end

  // Synchroniser and debouncer; any bounce back to the current level restarts the count
  always_comb begin
    sync_d          = {sync_q[SYNC_STAGES-2:0], key_n};
    key_level_d     = key_level_q;
    key_level_dly_d = key_level_q;
    db_cnt_d        = '0;
    if (sync_out != key_level_q) begin
      if (db_cnt_q == CW'(DEBOUNCE_CYCLES - 1)) key_level_d = sync_out;
      else                                      db_cnt_d    = db_cnt_q + 1'b1;
    end
  end

  assign run_expired = (RUN_TIMEOUT != 0) && (run_cnt_q == RW'(RUN_TIMEOUT - 1));

  // Next-state logic; done takes priority over timeout on the same edge
  always_comb begin
    state_d    = state_q;
    run_cnt_d  = run_cnt_q;
    timeout_d  = timeout_q;
    drop_cnt_d = drop_cnt_q;
    if (press && state_q != IDLE && drop_cnt_q != 8'hFF) drop_cnt_d = drop_cnt_q + 8'd1;
    case (state_q)
      IDLE: if (press) begin
        state_d   = START;
        timeout_d = 1'b0;
      end
      START: begin
        state_d   = RUN;
        run_cnt_d = '0;
      end
      RUN: begin
        if (done) state_d = IDLE;
        else if (run_expired) begin
          state_d   = IDLE;
          timeout_d = 1'b1;
        end else run_cnt_d = run_cnt_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with it
  always_comb begin
    start_d   = (state_d == START);
    running_d = (state_d == START) || (state_d == RUN);
  end

  assign start     = start_q;
  assign running   = running_q;
  assign key_level = key_level_q;
  assign drop_cnt  = drop_cnt_q;
  assign timeout   = timeout_q;

endmodule
